// File: rtl/regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_scheduler
// Purpose  : Round-robin writeback arbiter (ALU / load unit) for the single
//            register-file write port, plus a pending-write scoreboard used
//            by decode for RAW/WAW hazard detection.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32,
  localparam int AW        = $clog2(REG_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst,
  // ALU writeback source
  input  logic                  alu_valid,
  input  logic [AW-1:0]         alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  output logic                  alu_ready,
  // Load-unit writeback source
  input  logic                  mem_valid,
  input  logic [AW-1:0]         mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_ready,
  // Issue-side scoreboard interface
  input  logic                  issue_valid,
  input  logic [AW-1:0]         issue_rd,
  output logic                  issue_ready,
  input  logic [AW-1:0]         chk_rs1,
  input  logic [AW-1:0]         chk_rs2,
  output logic                  chk_rs1_busy,
  output logic                  chk_rs2_busy,
  // Register-file write port
  output logic                  rf_we,
  output logic [AW-1:0]         rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata
);

  // rr_last: 0 = ALU granted most recently, 1 = load granted most recently
  logic [REG_COUNT-1:0]  pending_q, pending_d;
  logic                  rr_last_q, rr_last_d;
  logic                  rf_we_q, rf_we_d;
  logic [AW-1:0]         rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;

  logic                  w_grant_alu;
  logic                  w_grant_mem;

  // Round-robin grant: a lone requester always wins, a tie goes to the
  // source that did not win last. Depends only on the valids and rr_last.
  always_comb begin
    w_grant_alu = alu_valid && (!mem_valid || rr_last_q);
    w_grant_mem = mem_valid && (!alu_valid || !rr_last_q);
  end

  assign alu_ready = w_grant_alu;
  assign mem_ready = w_grant_mem;

  // Hazard queries against the scoreboard; no bypass from the write in flight
  assign issue_ready  = (issue_rd == '0) || !pending_q[issue_rd];
  assign chk_rs1_busy = (chk_rs1 != '0) && pending_q[chk_rs1];
  assign chk_rs2_busy = (chk_rs2 != '0) && pending_q[chk_rs2];

  // Next-state: capture the granted write and update the round-robin pointer
  always_comb begin
    rr_last_d  = rr_last_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (w_grant_alu) begin
      rr_last_d = 1'b0;
      if (alu_rd != '0) begin
        rf_we_d    = 1'b1;
        rf_waddr_d = alu_rd;
        rf_wdata_d = alu_data;
      end
    end else if (w_grant_mem) begin
      rr_last_d = 1'b1;
      if (mem_rd != '0) begin
        rf_we_d    = 1'b1;
        rf_waddr_d = mem_rd;
        rf_wdata_d = mem_data;
      end
    end
  end

  // Next-state: scoreboard clears on the committing write, sets on issue.
  // A set and a clear never hit the same register in one cycle because a
  // pending register holds issue_ready low.
  always_comb begin
    pending_d = pending_q;
    if (rf_we_q) begin
      pending_d[rf_waddr_q] = 1'b0;
    end
    if (issue_valid && issue_ready && (issue_rd != '0)) begin
      pending_d[issue_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // State registers; reset drops any write captured at the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q  <= '0;
      rr_last_q  <= 1'b1;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      pending_q  <= pending_d;
      rr_last_q  <= rr_last_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_scheduler
// Purpose  : Self-checking bench: directed scenarios plus randomized traffic
//            compared against a behavioural scoreboard/arbiter model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_scheduler;
  localparam int DW = 32;
  localparam int RC = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid, mem_valid, issue_valid;
  logic [AW-1:0] alu_rd, mem_rd, issue_rd, chk_rs1, chk_rs2;
  logic [DW-1:0] alu_data, mem_data;
  logic          alu_ready, mem_ready, issue_ready, chk_rs1_busy, chk_rs2_busy;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;

  always #5 clk = ~clk;

  regfile_wb_scheduler #(.DATA_WIDTH(DW), .REG_COUNT(RC)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
    .chk_rs1_busy(chk_rs1_busy), .chk_rs2_busy(chk_rs2_busy),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  typedef struct packed {
    bit          rst;
    bit          av;
    bit [AW-1:0] ard;
    bit [DW-1:0] ad;
    bit          mv;
    bit [AW-1:0] mrd;
    bit [DW-1:0] md;
    bit          iv;
    bit [AW-1:0] ird;
    bit [AW-1:0] c1;
    bit [AW-1:0] c2;
  } stim_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: set of registers with uncommitted writes, who won the
  // last arbitration, and the write the register file should see next.
  bit [RC-1:0] m_pend;
  bit          m_last_mem;
  bit          m_we;
  bit [AW-1:0] m_waddr;
  bit [DW-1:0] m_wdata;
  bit          g_alu, g_mem;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  // Drives one cycle of stimulus (entered 1 time unit after a rising edge),
  // checks combinational outputs, advances the model and checks the
  // registered outputs just after the next rising edge.
  task automatic run_cycle(input stim_t s);
    bit          ga, gm, ir;
    bit [RC-1:0] np;
    bit          nl, nw;
    bit [AW-1:0] na, rd;
    bit [DW-1:0] nd;
    rst = s.rst;
    alu_valid = s.av; alu_rd = s.ard; alu_data = s.ad;
    mem_valid = s.mv; mem_rd = s.mrd; mem_data = s.md;
    issue_valid = s.iv; issue_rd = s.ird;
    chk_rs1 = s.c1; chk_rs2 = s.c2;
    #1;
    ga = s.av && (!s.mv || m_last_mem);
    gm = s.mv && !ga;
    ir = (s.ird == 0) || !m_pend[s.ird];
    check_eq("alu_ready", alu_ready, ga);
    check_eq("mem_ready", mem_ready, gm);
    check_eq("issue_ready", issue_ready, ir);
    check_eq("rs1_busy", chk_rs1_busy, (s.c1 != 0) && m_pend[s.c1]);
    check_eq("rs2_busy", chk_rs2_busy, (s.c2 != 0) && m_pend[s.c2]);
    g_alu = ga;
    g_mem = gm;
    if (s.rst) begin
      np = '0; nl = 1'b1; nw = 1'b0; na = '0; nd = '0;
    end else begin
      np = m_pend; nl = m_last_mem; nw = 1'b0; na = m_waddr; nd = m_wdata;
      if (m_we) np[m_waddr] = 1'b0;
      if (s.iv && ir && s.ird != 0) np[s.ird] = 1'b1;
      if (ga || gm) begin
        nl = gm;
        rd = ga ? s.ard : s.mrd;
        if (rd != 0) begin
          nw = 1'b1; na = rd; nd = ga ? s.ad : s.md;
        end
      end
    end
    @(posedge clk);
    m_pend = np; m_last_mem = nl; m_we = nw; m_waddr = na; m_wdata = nd;
    #1;
    check_eq("rf_we", rf_we, m_we);
    check_eq("rf_waddr", rf_waddr, m_waddr);
    check_eq("rf_wdata", rf_wdata, m_wdata);
  endtask

  initial begin
    stim_t       s;
    bit [AW-1:0] exp_seq [4];
    int          ai, mi;
    bit          a_hold, m_hold;
    bit [AW-1:0] a_rd, m_rd;
    bit [DW-1:0] a_dat, m_dat;

    rst = 1'b1;
    alu_valid = 0; mem_valid = 0; issue_valid = 0;
    alu_rd = 0; mem_rd = 0; issue_rd = 0; chk_rs1 = 0; chk_rs2 = 0;
    alu_data = 0; mem_data = 0;
    m_pend = '0; m_last_mem = 1'b1; m_we = 0; m_waddr = 0; m_wdata = 0;
    @(posedge clk); #1;

    // Reset held two cycles with every request asserted
    s = idle(); s.rst = 1; s.av = 1; s.ard = 4; s.ad = 32'h1111_1111;
    s.mv = 1; s.mrd = 6; s.md = 32'h2222_2222; s.iv = 1; s.ird = 3; s.c1 = 3; s.c2 = 4;
    run_cycle(s); run_cycle(s);
    s = idle(); s.c1 = 3; s.c2 = 4; s.ird = 3;
    run_cycle(s);

    // Contention: both sources continuously valid, ALU wins first tie
    exp_seq[0] = 1; exp_seq[1] = 9; exp_seq[2] = 2; exp_seq[3] = 10;
    ai = 0; mi = 0;
    for (int k = 0; k < 4; k++) begin
      s = idle();
      s.av = 1; s.ard = AW'(1 + ai); s.ad = 32'hA000_0000 + ai;
      s.mv = 1; s.mrd = AW'(9 + mi); s.md = 32'hB000_0000 + mi;
      run_cycle(s);
      check_eq("cont_waddr", rf_waddr, exp_seq[k]);
      if (g_alu) ai++;
      if (g_mem) mi++;
    end

    // Single write with scoreboard tracking
    s = idle(); s.iv = 1; s.ird = 5; run_cycle(s);
    s = idle(); s.av = 1; s.ard = 5; s.ad = 32'hDEAD_BEEF; s.c1 = 5; run_cycle(s);
    check_eq("single_waddr", rf_waddr, 5);
    check_eq("single_wdata", rf_wdata, 32'hDEAD_BEEF);
    s = idle(); s.c1 = 5; run_cycle(s);
    s = idle(); s.c1 = 5; run_cycle(s);

    // x0: issue and writeback to register 0 have no visible effect
    s = idle(); s.iv = 1; s.ird = 0; run_cycle(s);
    s = idle(); s.mv = 1; s.mrd = 0; s.md = 32'h1234; run_cycle(s);
    check_eq("x0_no_we", rf_we, 0);

    // WAW stall on rd=7, rd=8 unaffected
    s = idle(); s.iv = 1; s.ird = 7; run_cycle(s);
    s = idle(); s.ird = 7; s.c1 = 8; run_cycle(s);
    s = idle(); s.av = 1; s.ard = 7; s.ad = 32'h7777; s.ird = 7; run_cycle(s);
    s = idle(); s.ird = 7; run_cycle(s);
    s = idle(); s.ird = 7; run_cycle(s);
    s = idle(); s.iv = 1; s.ird = 8; run_cycle(s);

    // Reset coincident with a load handshake to a pending register
    s = idle(); s.iv = 1; s.ird = 3; run_cycle(s);
    s = idle(); s.rst = 1; s.mv = 1; s.mrd = 3; s.md = 32'h3333; s.c1 = 3; run_cycle(s);
    s = idle(); s.c1 = 3; s.ird = 3; run_cycle(s);

    // Randomized traffic; a stalled source holds its request stable
    a_hold = 0; m_hold = 0; a_rd = 0; m_rd = 0; a_dat = 0; m_dat = 0;
    for (int k = 0; k < 400; k++) begin
      s = idle();
      s.rst = ($urandom_range(0, 59) == 0);
      if (a_hold) s.av = 1;
      else begin
        s.av = 1'($urandom_range(0, 1));
        a_rd = AW'($urandom_range(0, 7)); a_dat = $urandom;
      end
      if (m_hold) s.mv = 1;
      else begin
        s.mv = 1'($urandom_range(0, 1));
        m_rd = AW'($urandom_range(0, 7)); m_dat = $urandom;
      end
      s.ard = a_rd; s.ad = a_dat; s.mrd = m_rd; s.md = m_dat;
      s.iv  = 1'($urandom_range(0, 1));
      s.ird = AW'($urandom_range(0, 7));
      s.c1  = AW'($urandom_range(0, 7));
      s.c2  = AW'($urandom_range(0, 7));
      run_cycle(s);
      a_hold = s.av && !g_alu;
      m_hold = s.mv && !g_mem;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
